dualmem_port_arb: RTL and testbench
===================================

DUALMEM_PORT_ARB -- requirements
Module: dualmem_port_arb

Interface
REQ-001 SHALL have parameter DATA_W, default 1260, memory word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 9, memory address width; depth is 2**ADDR_W (512).
REQ-003 SHALL have port clk, input, 1: single clock for all logic; one clock, reset is synchronous and active-low.
REQ-004 SHALL have port rstn, input, 1: synchronous active-low reset.
REQ-005 SHALL have port req_valid, input, 2: per-requester request valid.
REQ-006 SHALL have port req_ready, output, 2: per-requester grant; the request transfers when valid&ready are both high.
REQ-007 SHALL have port req_we, input, 2: per-requester write (1) or read (0).
REQ-008 SHALL have port req_addr, input, 2*ADDR_W: requester i address at [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port req_wdata, input, 2*DATA_W: requester i write data at [i*DATA_W +: DATA_W].
REQ-010 SHALL have port rsp_valid, output, 2: one-cycle read-response strobe per requester.
REQ-011 SHALL have port rsp_rdata, output, DATA_W: read data, shared, qualified by rsp_valid.
REQ-012 SHALL have port clr_start, input, 1: pulse that requests a full-memory clear.
REQ-013 SHALL have port clr_busy, output, 1: high while a clear is in progress.
REQ-014 SHALL have ports mem_en (out, 1), mem_we (out, 1), mem_addr (out, ADDR_W), mem_wdata (out, DATA_W) and mem_rdata (in, DATA_W), one port of the 512 x 1260 dual-port RAM, which has 1-cycle read latency.

Function
REQ-015 SHALL implement a two-state FSM: CLEAR and RUN.
REQ-016 In CLEAR, it SHALL write all-zero data to addresses 0..511 in ascending order, one per cycle: mem_en=1, mem_we=1, all req_ready=0, clr_busy=1.
REQ-017 CLEAR SHALL last exactly 2**ADDR_W cycles, then go to RUN in the cycle after address 511 is written.
REQ-018 In RUN, clr_start=1 SHALL enter CLEAR next cycle with the counter at 0; no grant is issued in that cycle.
REQ-019 clr_start during CLEAR SHALL be ignored; the clear does not restart.
REQ-020 In RUN, it SHALL grant at most one requester per cycle; req_ready is combinational from req_valid and the priority pointer.
REQ-021 With one requester valid, it SHALL be granted the same cycle.
REQ-022 With both valid, the requester selected by the round-robin pointer SHALL be granted.
REQ-023 After a grant to requester i, the pointer SHALL move to 1-i; with no grant, the pointer SHALL hold.
REQ-024 On a grant, mem_en=1, and mem_we/mem_addr/mem_wdata SHALL be the granted requester's fields; with no grant, mem_en=0 and mem_we=0.
REQ-025 A read grant to requester i in cycle N SHALL give rsp_valid[i]=1 in cycle N+1, with rsp_rdata=mem_rdata (combinational pass-through).
REQ-026 Writes SHALL produce no response.
REQ-027 A read granted in the cycle before entering CLEAR SHALL still get its response in the first CLEAR cycle.
REQ-028 A read followed by a write to the same address in the next cycle SHALL return the old data; ordering follows grant order.
REQ-029 Address fields SHALL be used unmodified; there is no address wrap or range check.

Reset
REQ-030 With rstn=0 at a clk edge: state=CLEAR, clear counter=0, pointer=requester 0, rsp_valid=0.
REQ-031 During reset, req_ready=0, mem_en=0, mem_we=0 and clr_busy=1.
REQ-032 The clear sequence SHALL begin in the first cycle after rstn rises.
REQ-033 Reset asserted mid-CLEAR or mid-read SHALL discard pending responses and restart the clear from 0.

Structure
REQ-034 A shared package SHALL hold the state enum {CLEAR, RUN}, ADDR_W/DATA_W defaults and the requester count (2).
REQ-035 The round-robin grant logic SHALL be a sub-module, rr_arb2 (inputs valid[1:0] and ptr; output one-hot grant).
REQ-036 The block SHALL contain no storage for data words; the memory is external.

Verification
REQ-037 Reset release: clr_busy SHALL be high for exactly 512 cycles, with mem_addr 0..511 and mem_wdata=0; then a read of address 0x1A5 SHALL return 0.
REQ-038 Requester 0 writes 0x...ABCD to address 7, then reads address 7: rsp_valid[0] SHALL pulse one cycle after the read grant with rsp_rdata=0x...ABCD; rsp_valid[1] SHALL stay 0.
REQ-039 Both requesters valid continuously for 6 cycles: grants SHALL alternate 0,1,0,1,0,1, starting with requester 0 after reset.
REQ-040 Requester 1 reads address 3 in the cycle before clr_start: its response SHALL arrive in the next cycle with the pre-clear data, and clr_busy SHALL then stay high for 512 cycles.
REQ-041 Reset asserted at clear address 200: after release, the clear SHALL restart at address 0 and complete all 512 addresses.
REQ-042 Requester 0 reads address 9 in cycle N and requester 1 writes address 9 in cycle N+1: requester 0 SHALL receive the old value.

Source files
------------

// File: rtl/dualmem_port_arb_pkg.sv
// Shared types and defaults for the dual-requester memory port arbiter.
// Holds the controller state encoding, the default geometry and the requester count.
package dualmem_port_arb_pkg;

  localparam int DATA_W_DEF = 1260;
  localparam int ADDR_W_DEF = 9;
  localparam int NUM_REQ    = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, and a tie goes to the
// requester named by ptr. The grant is one-hot or zero.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/dualmem_port_arb.sv
// Arbitrates two requesters onto one port of an external 1-cycle-latency RAM,
// and sweeps the whole RAM to zero after reset or on request.
//
// state | meaning
// ------+-----------------------------------------------------------------
// CLEAR | writing zero to every address in ascending order, requests held
// RUN   | round-robin grant of requests onto the RAM port
module dualmem_port_arb
  import dualmem_port_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  input  logic                        clr_start,
  output logic                        clr_busy,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);

  state_t              state_q, state_d;
  // Down-counter of addresses still to clear; the address itself is its complement,
  // so all-ones maps to address 0 and terminal count zero maps to the last address.
  logic [ADDR_W-1:0]   clr_left_q, clr_left_d;
  logic                ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ-1:0]  grant;
  logic                sel;

  rr_arb2 u_rr_arb2 (
    .valid (req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  assign sel = grant[1];

  always_comb begin
    state_d     = state_q;
    clr_left_d  = clr_left_q;
    ptr_d       = ptr_q;
    rsp_valid_d = '0;
    req_ready   = '0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    clr_busy    = 1'b0;

    case (state_q)
      CLEAR: begin
        mem_en     = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = ~clr_left_q;
        clr_busy   = 1'b1;
        clr_left_d = clr_left_q - 1'b1;
        if (clr_left_q == '0) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (clr_start) begin
          state_d    = CLEAR;
          clr_left_d = '1;
        end else begin
          req_ready = grant;
          if (|grant) begin
            mem_en      = 1'b1;
            mem_we      = req_we[sel];
            mem_addr    = sel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
            mem_wdata   = sel ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
            ptr_d       = ~sel;
            rsp_valid_d = grant & ~req_we;
          end
        end
      end
      default: state_d = CLEAR;
    endcase

    // Keep the RAM and requesters quiet while reset is held, even before the first edge.
    if (!rstn) begin
      req_ready = '0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      clr_busy  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= CLEAR;
      clr_left_q  <= '1;
      ptr_q       <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_left_q  <= clr_left_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = mem_rdata;

endmodule

// File: tb/tb_dualmem_port_arb.sv
// Bench for dualmem_port_arb: external RAM model, a per-cycle behavioural reference
// with a shadow memory, directed scenarios with literal expectations, then random traffic.
module tb_dualmem_port_arb;

  localparam int DATA_W = 1260;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 1 << ADDR_W;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [1:0]             req_we;
  logic [2*ADDR_W-1:0]    req_addr;
  logic [2*DATA_W-1:0]    req_wdata;
  logic [1:0]             rsp_valid;
  logic [DATA_W-1:0]      rsp_rdata;
  logic                   clr_start;
  logic                   clr_busy;
  logic                   mem_en;
  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic [DATA_W-1:0]      mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  dualmem_port_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // External RAM: read-first, one cycle read latency.
  logic [DATA_W-1:0] ram [0:DEPTH-1];
  logic [DATA_W-1:0] ram_q = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        ram_q <= ram[mem_addr];
    end
  end
  assign mem_rdata = ram_q;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual(lo64)=%0h expected(lo64)=%0h @%0t", nm, act[63:0], exp[63:0], $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W+31:0] t;
    t = '0;
    for (int k = 0; k < DATA_W; k += 32) t[k +: 32] = $urandom;
    return t[DATA_W-1:0];
  endfunction

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] shadow [0:DEPTH-1];
  bit                m_known = 0;
  bit                m_clr;
  int                m_caddr;
  int                m_prio;
  logic [1:0]        m_rsp;
  logic [DATA_W-1:0] m_rsp_data;
  int                cw;
  int                ca;

  always @(negedge clk) begin
    // winner of this cycle, if the model is arbitrating
    cw = -1;
    if (req_valid == 2'b11)   cw = m_prio;
    else if (req_valid[0])    cw = 0;
    else if (req_valid[1])    cw = 1;
    ca = (cw >= 0) ? int'(req_addr[cw*ADDR_W +: ADDR_W]) : 0;

    if (!rstn) begin
      chk("ctl_rst", {req_ready, mem_en, mem_we, clr_busy}, 5'b00001);
    end else if (m_known) begin
      if (m_clr) begin
        chk("ctl_clr", {req_ready, mem_en, mem_we, clr_busy}, 5'b00111);
        chk("clr_addr", mem_addr, m_caddr);
        chk_w("clr_wdata", mem_wdata, '0);
      end else if (clr_start) begin
        chk("ctl_clrstart", {req_ready, mem_en, mem_we, clr_busy}, 5'b00000);
      end else if (cw < 0) begin
        chk("ctl_idle", {req_ready, mem_en, mem_we, clr_busy}, 5'b00000);
      end else begin
        chk("ctl_grant", {req_ready, mem_en, mem_we, clr_busy},
            {(cw == 1) ? 2'b10 : 2'b01, 1'b1, req_we[cw], 1'b0});
        chk("grant_addr", mem_addr, ca);
        if (req_we[cw]) chk_w("grant_wdata", mem_wdata, req_wdata[cw*DATA_W +: DATA_W]);
      end
    end
    if (m_known) begin
      chk("rsp_valid", rsp_valid, m_rsp);
      if (m_rsp != 2'b00) chk_w("rsp_rdata", rsp_rdata, m_rsp_data);
    end

    // advance the model to reflect the coming rising edge
    if (!rstn) begin
      m_known = 1;
      m_clr   = 1;
      m_caddr = 0;
      m_prio  = 0;
      m_rsp   = 2'b00;
    end else if (m_known) begin
      m_rsp = 2'b00;
      if (m_clr) begin
        shadow[m_caddr] = '0;
        if (m_caddr == DEPTH-1) m_clr = 0;
        else m_caddr++;
      end else if (clr_start) begin
        m_clr   = 1;
        m_caddr = 0;
      end else if (cw >= 0) begin
        m_prio = 1 - cw;
        if (req_we[cw]) begin
          shadow[ca] = req_wdata[cw*DATA_W +: DATA_W];
        end else begin
          m_rsp[cw]  = 1'b1;
          m_rsp_data = shadow[ca];
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = '0;
    req_we    = '0;
    clr_start = 1'b0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    req_valid[i]                  = 1'b1;
    req_we[i]                     = we;
    req_addr[i*ADDR_W +: ADDR_W]  = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic do_req(input int i, input logic we, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d);
    idle();
    set_req(i, we, a, d);
    step();
    idle();
  endtask

  // Counts busy cycles from the current one; bounded so a stuck clear still ends.
  task automatic measure_clear(output int n, output int first_addr);
    n = 0;
    first_addr = -1;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (!clr_busy) break;
      if (n == 0) first_addr = int'(mem_addr);
      n++;
    end
    step();
  endtask

  logic [1:0]        exp_g [6];
  logic [DATA_W-1:0] v_abcd, v_old9, v_new9, v_3;
  int                n_busy, first_a;

  initial begin
    rstn      = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    idle();
    for (int a = 0; a < DEPTH; a++) begin
      ram[a]    = rand_word();
      shadow[a] = ram[a];
    end
    exp_g  = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    v_abcd = DATA_W'(16'hABCD);
    v_old9 = rand_word();
    v_new9 = rand_word();
    v_3    = rand_word();

    repeat (3) step();
    rstn = 1'b1;
    measure_clear(n_busy, first_a);
    chk("por_clr_len", n_busy, 512);
    chk("por_clr_first", first_a, 0);

    // both requesters continuously valid: strict alternation from requester 0
    set_req(0, 1'b0, 9'd20, '0);
    set_req(1, 1'b0, 9'd21, '0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("alt_grant%0d", k), req_ready, exp_g[k]);
      step();
    end
    idle();
    step();

    // cleared memory reads back zero
    do_req(0, 1'b0, 9'h1A5, '0);
    @(negedge clk);
    chk("rd1a5_valid", rsp_valid, 2'b01);
    chk_w("rd1a5_data", rsp_rdata, '0);
    step();

    // write then read back on requester 0
    do_req(0, 1'b1, 9'd7, v_abcd);
    do_req(0, 1'b0, 9'd7, '0);
    @(negedge clk);
    chk("rd7_valid", rsp_valid, 2'b01);
    chk_w("rd7_data", rsp_rdata, v_abcd);
    step();
    @(negedge clk);
    chk("rd7_pulse_end", rsp_valid, 2'b00);
    step();

    // read of 9 followed by a write of 9 from the other requester returns old data
    do_req(0, 1'b1, 9'd9, v_old9);
    set_req(0, 1'b0, 9'd9, '0);
    step();
    idle();
    set_req(1, 1'b1, 9'd9, v_new9);
    @(negedge clk);
    chk("raw9_ready", req_ready, 2'b10);
    chk("raw9_valid", rsp_valid, 2'b01);
    chk_w("raw9_data", rsp_rdata, v_old9);
    step();
    idle();
    do_req(1, 1'b0, 9'd9, '0);
    @(negedge clk);
    chk("raw9_after_valid", rsp_valid, 2'b10);
    chk_w("raw9_after_data", rsp_rdata, v_new9);
    step();

    // read just before a clear request still gets pre-clear data
    do_req(1, 1'b1, 9'd3, v_3);
    set_req(1, 1'b0, 9'd3, '0);
    step();
    idle();
    set_req(0, 1'b0, 9'd4, '0);
    clr_start = 1'b1;
    @(negedge clk);
    chk("pre_clr_ready", req_ready, 2'b00);
    chk("pre_clr_valid", rsp_valid, 2'b10);
    chk_w("pre_clr_data", rsp_rdata, v_3);
    step();
    idle();
    measure_clear(n_busy, first_a);
    chk("req_clr_len", n_busy, 512);
    chk("req_clr_first", first_a, 0);

    // clr_start mid-clear is ignored; reset mid-clear restarts from 0
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (clr_busy && mem_addr == 9'd199) break;
      if (!clr_busy) begin
        step();
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
    measure_clear(n_busy, first_a);
    chk("rst_mid_clr_len", n_busy, 512);
    chk("rst_mid_clr_first", first_a, 0);

    // random traffic against the reference model
    for (int k = 0; k < 4000; k++) begin
      req_valid = 2'($urandom);
      req_we    = 2'($urandom);
      for (int i = 0; i < 2; i++) begin
        req_addr[i*ADDR_W +: ADDR_W]  = ADDR_W'($urandom_range(0, 15));
        req_wdata[i*DATA_W +: DATA_W] = rand_word();
      end
      clr_start = ($urandom_range(0, 399) == 0);
      rstn      = ($urandom_range(0, 799) != 0);
      step();
    end
    idle();
    rstn = 1'b1;
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
